// File: rtl/traffic_pkg.sv
// Shared lamp encodings, phase codes and preempt-target type for the
// actuated intersection controller.
package traffic_pkg;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    typedef enum logic [2:0] {
        A_GRN   = 3'd0,
        A_YEL   = 3'd1,
        AR_TO_B = 3'd2,
        B_GRN   = 3'd3,
        B_YEL   = 3'd4,
        AR_TO_A = 3'd5
    } phase_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        TGT_A = 2'd1,
        TGT_B = 2'd2
    } pre_tgt_t;

endpackage

// File: rtl/phase_timer.sv
// Saturating tick counter for the current phase; clr beats tick so a phase
// change always starts the new phase at zero.
module phase_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             tick,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (tick && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/actuated_signal_controller.sv
// Demand-actuated, preemptible two-road signal sequencer. Green is bounded by
// min/max times; yellow and all-red clearance are always fully timed.
module actuated_signal_controller
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 15,
    parameter int YELLOW_T  = 2,
    parameter int ALL_RED_T = 1,
    parameter int CNT_W     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       det_a,
    input  logic       det_b,
    input  logic       preempt_a,
    input  logic       preempt_b,
    output logic [2:0] light_A,
    output logic [2:0] light_B,
    output logic [2:0] phase,
    output logic       preempt_active
);

    phase_t           phase_q, phase_d;
    pre_tgt_t         pre_tgt_q, pre_tgt_d;
    logic             dem_a_q, dem_a_d;
    logic             dem_b_q, dem_b_d;
    logic [CNT_W-1:0] timer;
    logic [31:0]      t1;
    logic             min_ok, max_hit, yel_done, ar_done;
    logic             hold_a, hold_b;
    logic             phase_chg;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (phase_chg),
        .tick  (tick),
        .count (timer)
    );

    // Expiry tests use timer+1 so a phase ends on the tick that completes it.
    assign t1       = 32'(timer) + 32'd1;
    assign min_ok   = (t1 >= MIN_GREEN);
    assign max_hit  = (t1 >= MAX_GREEN);
    assign yel_done = tick && (t1 >= YELLOW_T);
    assign ar_done  = tick && (t1 >= ALL_RED_T);

    assign hold_a   = (pre_tgt_q == TGT_A) && preempt_a;
    assign hold_b   = (pre_tgt_q == TGT_B) && preempt_b;

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            A_GRN: begin
                if (pre_tgt_q == TGT_B) begin
                    phase_d = A_YEL;
                end else if (!hold_a && tick && dem_b_q && min_ok && (!det_a || max_hit)) begin
                    phase_d = A_YEL;
                end
            end
            A_YEL:   if (yel_done) phase_d = AR_TO_B;
            AR_TO_B: if (ar_done)  phase_d = B_GRN;
            B_GRN: begin
                if (pre_tgt_q == TGT_A) begin
                    phase_d = B_YEL;
                end else if (!hold_b && tick && dem_a_q && min_ok && (!det_b || max_hit)) begin
                    phase_d = B_YEL;
                end
            end
            B_YEL:   if (yel_done) phase_d = AR_TO_A;
            AR_TO_A: if (ar_done)  phase_d = A_GRN;
            default: phase_d = AR_TO_A;
        endcase
    end

    assign phase_chg = (phase_d != phase_q);

    // Demand latches: entry into the road's own green clears, and wins over a set.
    always_comb begin
        dem_a_d = dem_a_q;
        dem_b_d = dem_b_q;
        if (det_a && (phase_q != A_GRN)) dem_a_d = 1'b1;
        if (det_b && (phase_q != B_GRN)) dem_b_d = 1'b1;
        if ((phase_d == A_GRN) && (phase_q != A_GRN)) dem_a_d = 1'b0;
        if ((phase_d == B_GRN) && (phase_q != B_GRN)) dem_b_d = 1'b0;
    end

    always_comb begin
        pre_tgt_d = pre_tgt_q;
        case (pre_tgt_q)
            NONE: begin
                if (preempt_a)      pre_tgt_d = TGT_A;
                else if (preempt_b) pre_tgt_d = TGT_B;
            end
            TGT_A:   if (!preempt_a && (phase_q == A_GRN)) pre_tgt_d = NONE;
            TGT_B:   if (!preempt_b && (phase_q == B_GRN)) pre_tgt_d = NONE;
            default: pre_tgt_d = NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q   <= AR_TO_A;
            pre_tgt_q <= NONE;
            dem_a_q   <= 1'b0;
            dem_b_q   <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            pre_tgt_q <= pre_tgt_d;
            dem_a_q   <= dem_a_d;
            dem_b_q   <= dem_b_d;
        end
    end

    always_comb begin
        light_A = LAMP_RED;
        light_B = LAMP_RED;
        case (phase_q)
            A_GRN:   light_A = LAMP_GRN;
            A_YEL:   light_A = LAMP_YEL;
            B_GRN:   light_B = LAMP_GRN;
            B_YEL:   light_B = LAMP_YEL;
            default: ;
        endcase
    end

    assign phase          = phase_q;
    assign preempt_active = (pre_tgt_q != NONE);

endmodule

// File: tb/tb_actuated_signal_controller.sv
// Directed bench: every cycle pushes the expected phase/preempt state to a
// scoreboard, then pops and compares it against the DUT after the edge.
module tb_actuated_signal_controller;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       reset, tick, det_a, det_b, preempt_a, preempt_b;
    logic [2:0] light_A, light_B, phase;
    logic       preempt_active;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    typedef struct {
        logic [2:0] ph;
        logic       pa;
        string      tag;
    } exp_t;
    exp_t sb[$];

    actuated_signal_controller dut (
        .clk            (clk),
        .reset          (reset),
        .tick           (tick),
        .det_a          (det_a),
        .det_b          (det_b),
        .preempt_a      (preempt_a),
        .preempt_b      (preempt_b),
        .light_A        (light_A),
        .light_B        (light_B),
        .phase          (phase),
        .preempt_active (preempt_active)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] lamps_for(input logic [2:0] ph);
        case (ph)
            3'd0:    return {LAMP_GRN, LAMP_RED};
            3'd1:    return {LAMP_YEL, LAMP_RED};
            3'd3:    return {LAMP_RED, LAMP_GRN};
            3'd4:    return {LAMP_RED, LAMP_YEL};
            default: return {LAMP_RED, LAMP_RED};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: queue the expectation, take the edge, compare at the falling edge.
    task automatic step(input logic [2:0] ph, input logic pa, input string tag);
        exp_t e;
        logic [9:0] want, got;
        e.ph = ph; e.pa = pa; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e    = sb.pop_front();
        want = {lamps_for(e.ph), e.ph, e.pa};
        got  = {light_A, light_B, phase, preempt_active};
        chk(e.tag, 16'(got), 16'(want));
    endtask

    task automatic steps(input int n, input logic [2:0] ph, input logic pa, input string tag);
        for (int i = 0; i < n; i++) step(ph, pa, tag);
    endtask

    task automatic run_reset();
        reset = 1'b1; det_a = 1'b0; det_b = 1'b0;
        preempt_a = 1'b0; preempt_b = 1'b0; tick = 1'b1;
        step(3'd5, 1'b0, "rst_hold1");
        step(3'd5, 1'b0, "rst_hold2");
        chk_en = 1'b1;
        reset = 1'b0;
        step(3'd0, 1'b0, "start_a_grn");
    endtask

    // Lamp safety: never both roads non-red.
    always @(negedge clk) begin
        if (chk_en) begin
            n_total++;
            assert ((light_A === LAMP_RED) || (light_B === LAMP_RED)) n_pass++;
            else $error("FAIL safety: observed A=%b B=%b required one red", light_A, light_B);
        end
    end

    initial begin
        reset = 1'b1; tick = 1'b1; det_a = 1'b0; det_b = 1'b0;
        preempt_a = 1'b0; preempt_b = 1'b0;
        @(negedge clk);

        // Start-up and idle rest
        run_reset();
        steps(100, 3'd0, 1'b0, "idle_rest");
        chk("idle_timer_sat", 16'(dut.u_timer.count), 16'd31);

        // Min green: det_b pulse at timer=1
        run_reset();
        step(3'd0, 1'b0, "mg_t1");
        det_b = 1'b1;
        step(3'd0, 1'b0, "mg_t2");
        det_b = 1'b0;
        steps(2, 3'd0, 1'b0, "mg_green");
        steps(2, 3'd1, 1'b0, "mg_yellow");
        step(3'd2, 1'b0, "mg_allred");
        step(3'd3, 1'b0, "mg_b_green");
        chk("mg_dem_b_clr", 16'(dut.dem_b_q), 16'd0);
        steps(3, 3'd3, 1'b0, "mg_b_rest");

        // Max green: det_a held, det_b pulse at timer=0
        run_reset();
        det_a = 1'b1; det_b = 1'b1;
        step(3'd0, 1'b0, "mx_t1");
        det_b = 1'b0;
        steps(13, 3'd0, 1'b0, "mx_green");
        step(3'd1, 1'b0, "mx_yellow");
        det_a = 1'b0;
        step(3'd1, 1'b0, "mx_yellow2");
        step(3'd2, 1'b0, "mx_allred");

        // Preempt B from A green at timer=1
        run_reset();
        step(3'd0, 1'b0, "pb_t1");
        preempt_b = 1'b1;
        step(3'd0, 1'b1, "pb_latch");
        steps(2, 3'd1, 1'b1, "pb_yellow");
        step(3'd2, 1'b1, "pb_allred");
        step(3'd3, 1'b1, "pb_b_green");
        det_a = 1'b1;
        steps(40, 3'd3, 1'b1, "pb_hold");
        preempt_b = 1'b0;
        step(3'd4, 1'b0, "pb_drop_yel");
        step(3'd4, 1'b0, "pb_yel2");
        det_a = 1'b0;
        step(3'd5, 1'b0, "pb_allred_a");
        step(3'd0, 1'b0, "pb_a_green");

        // Tie in B green goes to A
        run_reset();
        step(3'd0, 1'b0, "tie_t1");
        det_b = 1'b1;
        step(3'd0, 1'b0, "tie_t2");
        det_b = 1'b0;
        steps(2, 3'd0, 1'b0, "tie_green");
        steps(2, 3'd1, 1'b0, "tie_yellow");
        step(3'd2, 1'b0, "tie_allred");
        step(3'd3, 1'b0, "tie_b_green");
        preempt_a = 1'b1; preempt_b = 1'b1;
        step(3'd3, 1'b1, "tie_latch");
        steps(2, 3'd4, 1'b1, "tie_b_yel");
        step(3'd5, 1'b1, "tie_allred");
        steps(6, 3'd0, 1'b1, "tie_a_hold");
        preempt_a = 1'b0; preempt_b = 1'b0;
        step(3'd0, 1'b0, "tie_release");

        // Reset during A yellow with a preempt and demand latched
        det_b = 1'b1;
        step(3'd0, 1'b0, "mr_dem_b");
        det_b = 1'b0;
        step(3'd1, 1'b0, "mr_a_yel");
        det_a = 1'b1; preempt_b = 1'b1;
        step(3'd1, 1'b1, "mr_yel_pre");
        reset = 1'b1; det_a = 1'b0; preempt_b = 1'b0;
        step(3'd5, 1'b0, "mr_reset");
        chk("mr_dem_a_clr", 16'(dut.dem_a_q), 16'd0);
        chk("mr_dem_b_clr", 16'(dut.dem_b_q), 16'd0);
        reset = 1'b0;
        step(3'd0, 1'b0, "mr_restart");

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
